// File: rtl/csa_seq_pkg.sv
// Shared types and parameter legality helpers for the segmented conditional-sum adder.
package csa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csa_seq_state_t;

  localparam int unsigned NUM_LEGAL_SEG  = 7;
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned LEGAL_SEG_WIDTHS [NUM_LEGAL_SEG] = '{1, 2, 4, 8, 16, 32, 64};

  // True when w is one of the slice widths the csa_block tree supports.
  function automatic bit is_legal_seg_width(input int unsigned w);
    bit legal;
    legal = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_SEG; i++) begin
      if (LEGAL_SEG_WIDTHS[i] == w) legal = 1'b1;
    end
    return legal;
  endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational conditional-sum adder; width must be a power of two.
module csa_block #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic [DATA_WIDTH-1:0] o_sum_c,
  output logic                  o_cout_c
);

  localparam int unsigned LVLS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 0;

  // Each level merges pairs of groups: the upper half picks its carry-0/carry-1
  // precomputed sum using the lower half's conditional carries.
  function automatic logic [DATA_WIDTH:0] cond_sum(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  cin
  );
    logic [DATA_WIDTH-1:0] s0, s1, k0, k1, nk0, nk1;
    int unsigned grp, half, lo;
    s0 = a ^ b;
    s1 = ~(a ^ b);
    k0 = a & b;
    k1 = a | b;
    for (int unsigned lvl = 1; lvl <= LVLS; lvl++) begin
      grp  = 32'(1) << lvl;
      half = grp >> 1;
      nk0  = '0;
      nk1  = '0;
      for (int unsigned g = 0; g < DATA_WIDTH / grp; g++) begin
        lo = g * grp;
        for (int unsigned j = half; j < grp; j++) begin
          {s1[lo+j], s0[lo+j]} = {(k1[2*g] ? s1[lo+j] : s0[lo+j]),
                                  (k0[2*g] ? s1[lo+j] : s0[lo+j])};
        end
        nk0[g] = k0[2*g] ? k1[2*g+1] : k0[2*g+1];
        nk1[g] = k1[2*g] ? k1[2*g+1] : k0[2*g+1];
      end
      k0 = nk0;
      k1 = nk1;
    end
    return cin ? {k1[0], s1} : {k0[0], s0};
  endfunction

  assign {o_cout_c, o_sum_c} = cond_sum(i_a, i_b, i_cin);

endmodule

// File: rtl/csa_segmented_adder.sv
// Wide adder that streams SEG_WIDTH slices through one csa_block, carry registered between slices.
module csa_segmented_adder
  import csa_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SEG_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_cout,
  output logic                  busy
);

  localparam int unsigned NSEG  = DATA_WIDTH / SEG_WIDTH;
  localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  if (!is_legal_seg_width(SEG_WIDTH) || (DATA_WIDTH == 0) ||
      (DATA_WIDTH > MAX_DATA_WIDTH) || ((DATA_WIDTH % SEG_WIDTH) != 0)) begin : g_bad_params
    $error("csa_segmented_adder: illegal DATA_WIDTH=%0d / SEG_WIDTH=%0d", DATA_WIDTH, SEG_WIDTH);
  end

  csa_seq_state_t        r_state;
  csa_seq_state_t        w_state_nxt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_carry;
  logic [IDX_W-1:0]      r_seg_idx;
  logic                  w_in_ready;
  logic                  w_load;
  logic                  w_step;
  logic [SEG_WIDTH-1:0]  w_seg_sum;
  logic                  w_seg_cout;
  logic [DATA_WIDTH-1:0] w_sum_shift;

  csa_block #(.DATA_WIDTH(SEG_WIDTH)) u_csa_block (
    .i_a      (r_a[SEG_WIDTH-1:0]),
    .i_b      (r_b[SEG_WIDTH-1:0]),
    .i_cin    (r_carry),
    .o_sum_c  (w_seg_sum),
    .o_cout_c (w_seg_cout)
  );

  // New slice enters at the MSB end so the finished word lands LSB-aligned.
  assign w_sum_shift = DATA_WIDTH'({w_seg_sum, r_sum} >> SEG_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = rst_n;
        if (in_valid && rst_n) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_seg_idx == LAST_IDX) w_state_nxt = DONE;
      end
      DONE: begin
        w_in_ready = rst_n && out_ready;
        if (out_ready) begin
          w_state_nxt = IDLE;
          if (in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, running carry and segment counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_seg_idx <= '0;
    end else if (w_load) begin
      r_a       <= in_a;
      r_b       <= in_b;
      r_carry   <= in_cin;
      r_seg_idx <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> SEG_WIDTH;
      r_b     <= r_b >> SEG_WIDTH;
      r_sum   <= w_sum_shift;
      r_carry <= w_seg_cout;
      if (r_seg_idx != LAST_IDX) r_seg_idx <= r_seg_idx + IDX_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;

endmodule

// File: tb/tb_csa_segmented_adder.sv
// Self-checking bench: directed cases on three width configurations plus randomized streaming traffic.
module tb_csa_segmented_adder;

  localparam int unsigned DW = 64;
  localparam int unsigned NI = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid  [NI];
  logic          in_ready  [NI];
  logic [DW-1:0] in_a      [NI];
  logic [DW-1:0] in_b      [NI];
  logic          in_cin    [NI];
  logic          out_valid [NI];
  logic          out_ready [NI];
  logic [DW-1:0] out_sum   [NI];
  logic          out_cout  [NI];
  logic          busy      [NI];

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  csa_segmented_adder #(.DATA_WIDTH(64), .SEG_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(out_sum[0]), .out_cout(out_cout[0]), .busy(busy[0])
  );

  csa_segmented_adder #(.DATA_WIDTH(64), .SEG_WIDTH(64)) u_dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(out_sum[1]), .out_cout(out_cout[1]), .busy(busy[1])
  );

  csa_segmented_adder #(.DATA_WIDTH(64), .SEG_WIDTH(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_cin(in_cin[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_sum(out_sum[2]), .out_cout(out_cout[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + 65'(cin);
  endfunction

  // Call right after an accepting edge; counts edges until out_valid is seen.
  task automatic wait_result(input int k, output int lat);
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid[k]) break;
    end
  endtask

  task automatic run_one(input int k, input logic [63:0] a, input logic [63:0] b, input logic cin,
                         output int lat, output logic [64:0] res);
    @(negedge clk);
    in_a[k] = a; in_b[k] = b; in_cin[k] = cin; in_valid[k] = 1'b1; out_ready[k] = 1'b0;
    for (int i = 0; i < 200 && !in_ready[k]; i++) @(negedge clk);
    check($sformatf("ready_%0d", k), 128'(in_ready[k]), 128'(1));
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_a[k] = {$urandom, $urandom}; in_b[k] = {$urandom, $urandom}; in_cin[k] = ~cin;
    wait_result(k, lat);
    res = {out_cout[k], out_sum[k]};
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [64:0] res;
    logic [64:0] exp1, exp2;
    logic [63:0] a, b;
    logic        cin;
    logic [64:0] exp_q[$];
    int          n_recv;
    logic        held, seen_valid;
    logic [64:0] held_val;

    n_checks = 0; n_fail = 0; n_recv = 0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; in_cin[k] = 1'b0; out_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_in_ready_%0d", k), 128'(in_ready[k]), 128'(0));
      check($sformatf("rst_out_valid_%0d", k), 128'(out_valid[k]), 128'(0));
      check($sformatf("rst_out_sum_%0d", k), 128'(out_sum[k]), 128'(0));
      check($sformatf("rst_out_cout_%0d", k), 128'(out_cout[k]), 128'(0));
      check($sformatf("rst_busy_%0d", k), 128'(busy[k]), 128'(0));
    end
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 128'(in_ready[0]), 128'(1));

    // Carry ripples through every segment.
    run_one(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, res);
    check("ripple_lat", 128'(lat), 128'(4));
    check("ripple_res", 128'(res), 128'({1'b1, 64'h0}));

    run_one(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, lat, res);
    check("comp_cin0_res", 128'(res), 128'({1'b0, 64'hFFFF_FFFF_FFFF_FFFF}));
    check("comp_cin0_lat", 128'(lat), 128'(4));
    run_one(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, lat, res);
    check("comp_cin1_res", 128'(res), 128'({1'b1, 64'h0}));

    // Backpressure with a second pair waiting.
    exp1 = ref_add(64'hDEAD_BEEF_0000_FFFF, 64'hF000_0001_FFFF_0001, 1'b1);
    exp2 = ref_add(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    @(negedge clk);
    in_a[0] = 64'hDEAD_BEEF_0000_FFFF; in_b[0] = 64'hF000_0001_FFFF_0001; in_cin[0] = 1'b1;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    check("bp_first_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk);
    #1;
    in_a[0] = 64'h7FFF_FFFF_FFFF_FFFF; in_b[0] = 64'h1; in_cin[0] = 1'b0;
    wait_result(0, lat);
    check("bp_first_lat", 128'(lat), 128'(4));
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 128'(out_valid[0]), 128'(1));
      check("bp_hold_res", 128'({out_cout[0], out_sum[0]}), 128'(exp1));
      check("bp_hold_in_ready", 128'(in_ready[0]), 128'(0));
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1;
    check("bp_release_in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    wait_result(0, lat);
    check("bp_second_lat", 128'(lat), 128'(4));
    check("bp_second_res", 128'({out_cout[0], out_sum[0]}), 128'(exp2));
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;

    // Reset in the middle of RUN discards the transaction.
    @(negedge clk);
    in_a[0] = 64'h1234_5678_9ABC_DEF0; in_b[0] = 64'h0FED_CBA9_8765_4321; in_cin[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy[0]), 128'(0));
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_out_sum", 128'(out_sum[0]), 128'(0));
    check("mid_rst_out_cout", 128'(out_cout[0]), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_ready", 128'(in_ready[0]), 128'(1));
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0]) seen_valid = 1'b1;
    end
    check("mid_rst_no_valid", 128'(seen_valid), 128'(0));
    run_one(0, 64'h10, 64'h20, 1'b1, lat, res);
    check("post_rst_res", 128'(res), 128'({1'b0, 64'h31}));
    check("post_rst_lat", 128'(lat), 128'(4));

    // Single-segment and single-bit-slice configurations.
    run_one(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, lat, res);
    check("w64_res", 128'(res), 128'({1'b1, 64'h0}));
    check("w64_lat", 128'(lat), 128'(1));
    run_one(2, 64'h3, 64'h5, 1'b0, lat, res);
    check("s1_res", 128'(res), 128'({1'b0, 64'h8}));
    check("s1_lat", 128'(lat), 128'(64));
    for (int k = 1; k < NI; k++) begin
      for (int n = 0; n < 3; n++) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom_range(0, 1));
        run_one(k, a, b, cin, lat, res);
        check($sformatf("cfg%0d_rand_res", k), 128'(res), 128'(ref_add(a, b, cin)));
      end
    end

    // Random streaming with gaps on the producer side and random out_ready.
    held = 1'b0; held_val = '0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [63:0] ra, rb;
          logic        rc;
          int          gap;
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          ra = {$urandom, $urandom};
          rb = ($urandom_range(0, 3) == 0) ? ~ra : {$urandom, $urandom};
          rc = 1'($urandom_range(0, 1));
          in_a[0] = ra; in_b[0] = rb; in_cin[0] = rc; in_valid[0] = 1'b1;
          for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (in_ready[0]) break;
          end
          if (!in_ready[0]) begin
            check("rand_accept_timeout", 128'(in_ready[0]), 128'(1));
            break;
          end
          exp_q.push_back(ref_add(ra, rb, rc));
          @(posedge clk);
          #1;
          in_valid[0] = 1'b0;
        end
      end
      begin
        for (int t = 0; t < 40000 && n_recv < 1000; t++) begin
          @(posedge clk);
          #1;
          out_ready[0] = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (out_valid[0]) begin
            if (held) check("rand_stable", 128'({out_cout[0], out_sum[0]}), 128'(held_val));
            if (out_ready[0]) begin
              held = 1'b0;
              if (exp_q.size() == 0) check("rand_extra_result", 128'(1), 128'(0));
              else check("rand_result", 128'({out_cout[0], out_sum[0]}), 128'(exp_q.pop_front()));
              n_recv++;
            end else begin
              held     = 1'b1;
              held_val = {out_cout[0], out_sum[0]};
            end
          end
        end
      end
    join
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    check("rand_count", 128'(n_recv), 128'(1000));
    check("rand_leftover", 128'(exp_q.size()), 128'(0));
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[0]) seen_valid = 1'b1;
    end
    check("rand_no_duplicate", 128'(seen_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
